// File: rtl/maxpool2d_stream_pkg.sv
// -----------------------------------------------------------------------------
// maxpool2d_stream_pkg
//   Shared constants and helpers for the streaming 2x2/stride-2 max-pool stage.
//   No ports; imported by the pool top and its interface.
// -----------------------------------------------------------------------------
package maxpool2d_stream_pkg;

    // Default geometry: matches the pointwise conv that feeds this stage.
    localparam int N_DEF          = 16;
    localparam int CHANNEL_DEF    = 32;
    localparam int INPUT_SIZE_DEF = 6;

    // Counter width for a 0..n-1 counter, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/maxpool2d_stream_if.sv
// -----------------------------------------------------------------------------
// maxpool2d_stream_if
//   Pixel stream into and pooled-pixel stream out of the max-pool stage.
//   Signals:
//     pool_din_vld   input pixel valid, one beat = one pixel
//     pool_din       input pixel, channel i at [(i+1)*N-1:i*N]
//     pool_dout      pooled pixel, same channel packing
//     pool_dout_vld  one-cycle pulse per pooled pixel
//     pool_dout_end  one-cycle pulse with the last pooled pixel of a frame
//   Modports:
//     master  upstream/observer side (drives pixels, receives pooled pixels)
//     slave   the pool stage itself
// -----------------------------------------------------------------------------
interface maxpool2d_stream_if #(
    parameter int N       = 16,
    parameter int CHANNEL = 32
);
    logic                   pool_din_vld;
    logic [CHANNEL*N-1:0]   pool_din;
    logic [CHANNEL*N-1:0]   pool_dout;
    logic                   pool_dout_vld;
    logic                   pool_dout_end;

    modport master (
        output pool_din_vld,
        output pool_din,
        input  pool_dout,
        input  pool_dout_vld,
        input  pool_dout_end
    );

    modport slave (
        input  pool_din_vld,
        input  pool_din,
        output pool_dout,
        output pool_dout_vld,
        output pool_dout_end
    );
endinterface

// File: rtl/maxpool2d_stream_signed_max2.sv
// -----------------------------------------------------------------------------
// signed_max2
//   Combinational signed maximum of two N-bit two's complement operands.
//   Ports:
//     a, b  signed operands
//     y     max(a, b); equal operands return that same value
// -----------------------------------------------------------------------------
module signed_max2 #(
    parameter int N = 16
) (
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    output logic signed [N-1:0] y
);
    assign y = (a > b) ? a : b;
endmodule

// File: rtl/maxpool2d_stream.sv
// -----------------------------------------------------------------------------
// maxpool2d_stream
//   Streaming 2x2/stride-2 max-pool. Takes one pixel per valid beat (all
//   channels in parallel, raster order) and emits one pooled pixel per 2x2
//   window in raster order, plus an end-of-frame pulse on the last output.
//   Horizontal maxima of each even row are parked in a half-width line buffer
//   and combined with the odd row's horizontal maxima to form the output.
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     pif    slave side of maxpool2d_stream_if (pixel in, pooled pixel out)
//   No backpressure: every pool_dout_vld beat must be accepted downstream.
// -----------------------------------------------------------------------------
module maxpool2d_stream
    import maxpool2d_stream_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int CHANNEL    = CHANNEL_DEF,
    parameter int INPUT_SIZE = INPUT_SIZE_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    maxpool2d_stream_if.slave   pif
);
    localparam int W    = CHANNEL * N;
    localparam int CW   = cnt_w(INPUT_SIZE);
    localparam int HALF = INPUT_SIZE / 2;
    localparam int LW   = cnt_w(HALF);
    localparam logic [CW-1:0] LAST = CW'(INPUT_SIZE - 1);

    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic [W-1:0]  hold_p0;
    logic [W-1:0]  line_buf [HALF];
    logic [LW-1:0] lb_idx;
    logic [W-1:0]  lb_rd;
    logic [W-1:0]  hmax;
    logic [W-1:0]  vmax;

    logic [W-1:0]  dout_p1;
    logic          vld_p1;
    logic          end_p1;

    // One line-buffer entry per horizontal pair: the pair index is col/2.
    assign lb_idx = LW'(col >> 1);
    assign lb_rd  = line_buf[lb_idx];

    // Stage 0: per-channel horizontal max (held even-col pixel vs current
    // odd-col pixel), then vertical max against the stored even-row result.
    for (genvar c = 0; c < CHANNEL; c++) begin : g_ch
        signed_max2 #(.N(N)) u_hmax (
            .a (hold_p0[c*N +: N]),
            .b (pif.pool_din[c*N +: N]),
            .y (hmax[c*N +: N])
        );
        signed_max2 #(.N(N)) u_vmax (
            .a (lb_rd[c*N +: N]),
            .b (hmax[c*N +: N]),
            .y (vmax[c*N +: N])
        );
    end

    // Counters, hold register and output register. Everything advances only
    // on valid beats; vld/end default low so they pulse for a single cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col     <= '0;
            row     <= '0;
            hold_p0 <= '0;
            dout_p1 <= '0;
            vld_p1  <= 1'b0;
            end_p1  <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            end_p1 <= 1'b0;
            if (pif.pool_din_vld) begin
                if (col == LAST) begin
                    col <= '0;
                    row <= (row == LAST) ? '0 : row + CW'(1);
                end else begin
                    col <= col + CW'(1);
                end

                // INPUT_SIZE is even, so bit 0 gives the parity of col/row.
                if (!col[0]) begin
                    hold_p0 <= pif.pool_din;
                end else if (row[0]) begin
                    // Stage 1: bottom-right pixel of a window completes it.
                    dout_p1 <= vmax;
                    vld_p1  <= 1'b1;
                    end_p1  <= (row == LAST) && (col == LAST);
                end
            end
        end
    end

    // Line buffer holds data only; every entry is rewritten on the even row
    // before the odd row reads it, so it needs no reset.
    always_ff @(posedge clk) begin
        if (rst_n && pif.pool_din_vld && col[0] && !row[0]) begin
            line_buf[lb_idx] <= hmax;
        end
    end

    assign pif.pool_dout     = dout_p1;
    assign pif.pool_dout_vld = vld_p1;
    assign pif.pool_dout_end = end_p1;

endmodule

// File: tb/tb_maxpool2d_stream.sv
// -----------------------------------------------------------------------------
// tb_maxpool2d_stream
//   Directed bench for maxpool2d_stream. A 4x4, 2-channel instance exercises
//   ramps, gaps, back-to-back frames, sign extremes and mid-frame reset; a
//   6x6, 32-channel instance runs random frames against a reference model.
// -----------------------------------------------------------------------------
module tb_maxpool2d_stream;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    maxpool2d_stream_if #(.N(16), .CHANNEL(2))  sif ();
    maxpool2d_stream_if #(.N(16), .CHANNEL(32)) bif ();

    maxpool2d_stream #(.N(16), .CHANNEL(2), .INPUT_SIZE(4)) u_small (
        .clk   (clk),
        .rst_n (rst_n),
        .pif   (sif)
    );

    maxpool2d_stream #(.N(16), .CHANNEL(32), .INPUT_SIZE(6)) u_big (
        .clk   (clk),
        .rst_n (rst_n),
        .pif   (bif)
    );

    int checks = 0;
    int errors = 0;

    // Small-instance frame: per-pixel ch0/ch1 values and per-window results.
    int f0 [16];
    int f1 [16];
    int e0 [4];
    int e1 [4];

    // Big-instance frame storage for the reference model.
    logic [511:0] pix [36];

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_ramp(input int offset);
        for (int p = 0; p < 16; p++) begin
            f0[p] = p + offset;
            f1[p] = -p;
        end
        e0[0] = 5 + offset;  e0[1] = 7 + offset;  e0[2] = 13 + offset;  e0[3] = 15 + offset;
        e1[0] = 0;           e1[1] = -2;          e1[2] = -8;           e1[3] = -10;
    endtask

    task automatic load_extremes();
        int a0 [16] = '{-32768, 32767, -32768, -32768,
                            -1,     0, -32768, -32768,
                             7,     7,      3,     -5,
                             7,     7,      3,      2};
        int a1 [16] = '{ 100, -100, 0, 0,
                        -200,   99, 0, 0,
                          -1,   -2, 1, 1,
                          -3,   -4, 1, 1};
        for (int p = 0; p < 16; p++) begin
            f0[p] = a0[p];
            f1[p] = a1[p];
        end
        e0[0] = 32767; e0[1] = -32768; e0[2] = 7;  e0[3] = 3;
        e1[0] = 100;   e1[1] = 0;      e1[2] = -1; e1[3] = 1;
    endtask

    // Feed the first nbeats pixels of the loaded 4x4 frame; check vld/end
    // after every beat, dout on each window-completing beat, quiet in gaps.
    task automatic feed_small(input int nbeats, input int gapmax, input string name);
        for (int p = 0; p < nbeats; p++) begin
            int r = p / 4;
            int c = p % 4;
            int k = (r / 2) * 2 + (c / 2);
            bit trig = (r % 2 == 1) && (c % 2 == 1);
            bit last = (p == 15);
            int g;
            logic [31:0] d;
            logic [31:0] ex;
            d  = {f1[p][15:0], f0[p][15:0]};
            ex = {e1[k][15:0], e0[k][15:0]};
            sif.pool_din     = d;
            sif.pool_din_vld = 1'b1;
            @(posedge clk);
            #1;
            sif.pool_din_vld = 1'b0;
            check($sformatf("%s p%0d vld", name, p), 512'(sif.pool_dout_vld), 512'(trig));
            check($sformatf("%s p%0d end", name, p), 512'(sif.pool_dout_end), 512'(trig && last));
            if (trig)
                check($sformatf("%s p%0d dout", name, p), 512'(sif.pool_dout), 512'(ex));
            g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
            repeat (g) begin
                @(posedge clk);
                #1;
                check($sformatf("%s p%0d gap vld", name, p), 512'(sif.pool_dout_vld), 512'(0));
            end
        end
    endtask

    function automatic logic [511:0] ref_pool(input int r, input int c);
        logic [511:0] res;
        logic signed [15:0] m;
        logic signed [15:0] v;
        int idx [4];
        res = '0;
        idx[0] = (r - 1) * 6 + c - 1;
        idx[1] = (r - 1) * 6 + c;
        idx[2] = r * 6 + c - 1;
        idx[3] = r * 6 + c;
        for (int ch = 0; ch < 32; ch++) begin
            m = pix[idx[0]][ch*16 +: 16];
            for (int j = 1; j < 4; j++) begin
                v = pix[idx[j]][ch*16 +: 16];
                if (v > m) m = v;
            end
            res[ch*16 +: 16] = m;
        end
        return res;
    endfunction

    task automatic feed_big(input int fr);
        int outs = 0;
        for (int p = 0; p < 36; p++) begin
            for (int ch = 0; ch < 32; ch++) begin
                case ($urandom_range(0, 7))
                    0:       pix[p][ch*16 +: 16] = 16'h8000;
                    1:       pix[p][ch*16 +: 16] = 16'h7fff;
                    default: pix[p][ch*16 +: 16] = 16'($urandom);
                endcase
            end
        end
        for (int p = 0; p < 36; p++) begin
            int r = p / 6;
            int c = p % 6;
            bit trig = (r % 2 == 1) && (c % 2 == 1);
            int g;
            bif.pool_din     = pix[p];
            bif.pool_din_vld = 1'b1;
            @(posedge clk);
            #1;
            bif.pool_din_vld = 1'b0;
            if (bif.pool_dout_vld) outs++;
            check($sformatf("big f%0d p%0d vld", fr, p), 512'(bif.pool_dout_vld), 512'(trig));
            check($sformatf("big f%0d p%0d end", fr, p), 512'(bif.pool_dout_end), 512'(p == 35));
            if (trig)
                check($sformatf("big f%0d p%0d dout", fr, p), bif.pool_dout, ref_pool(r, c));
            g = int'($urandom_range(0, 1));
            repeat (g) begin
                @(posedge clk);
                #1;
                check($sformatf("big f%0d p%0d gap vld", fr, p), 512'(bif.pool_dout_vld), 512'(0));
            end
        end
        check($sformatf("big f%0d output count", fr), 512'(outs), 512'(9));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired before the end of the directed sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        sif.pool_din_vld = 1'b0;
        sif.pool_din     = '0;
        bif.pool_din_vld = 1'b0;
        bif.pool_din     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset dout",     512'(sif.pool_dout),     512'(0));
        check("reset vld",      512'(sif.pool_dout_vld), 512'(0));
        check("reset end",      512'(sif.pool_dout_end), 512'(0));
        check("reset big vld",  512'(bif.pool_dout_vld), 512'(0));
        check("reset big dout", bif.pool_dout,           512'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: ramp back-to-back
        load_ramp(0);
        feed_small(16, 0, "s1");

        // 2: ramp with random 0-3 cycle gaps
        feed_small(16, 3, "s2");

        // 3: two frames back-to-back, second offset by 100 on ch0
        feed_small(16, 0, "s3a");
        load_ramp(100);
        feed_small(16, 0, "s3b");

        // 4: sign extremes and ties
        load_extremes();
        feed_small(16, 1, "s4");

        // 5: reset after 9 beats, then a full ramp frame
        load_ramp(0);
        feed_small(9, 0, "s5 partial");
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("s5 reset dout", 512'(sif.pool_dout),     512'(0));
        check("s5 reset vld",  512'(sif.pool_dout_vld), 512'(0));
        check("s5 reset end",  512'(sif.pool_dout_end), 512'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        feed_small(16, 0, "s5");

        // 6: 6x6, 32-channel random frames against the reference model
        for (int fr = 0; fr < 3; fr++) feed_big(fr);

        @(posedge clk);
        #1;
        check("idle small vld", 512'(sif.pool_dout_vld), 512'(0));
        check("idle big vld",   512'(bif.pool_dout_vld), 512'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
